// File: rtl/period_meter.sv
// Measures period and high time of a slow periodic input in clk_in cycles,
// with a sticky loss-of-signal timeout.
module period_meter #(
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 sig_in,
   input  logic                 enable,
   output logic [CNT_WIDTH-1:0] period_out,
   output logic [CNT_WIDTH-1:0] high_out,
   output logic                 valid,
   output logic                 timeout,
   output logic                 measuring
);

   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_sync;
   logic                   s_prev;
   logic                   rise;
   logic                   fall;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]   hi_cap_q, hi_cap_d;
   logic [CNT_WIDTH-1:0]   period_d, high_d;
   logic                   valid_d, timeout_d;

   assign s_sync    = sync_q[SYNC_STAGES-1];
   assign rise      = s_sync & ~s_prev;
   assign fall      = ~s_sync & s_prev;
   assign measuring = (state_q == MEAS);

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         sync_q     <= '0;
         s_prev     <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_cap_q   <= '0;
         period_out <= '0;
         high_out   <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_prev     <= s_sync;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_cap_q   <= hi_cap_d;
         period_out <= period_d;
         high_out   <= high_d;
         valid      <= valid_d;
         timeout    <= timeout_d;
      end
   end

   // A rise is checked before the limit so a period equal to the limit still measures.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_cap_d  = hi_cap_q;
      period_d  = period_out;
      high_d    = high_out;
      valid_d   = 1'b0;
      timeout_d = timeout;

      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = ARM;
            end
            ARM: begin
               if (rise) begin
                  cnt_d    = CNT_ONE;
                  hi_cap_d = '0;
                  state_d  = MEAS;
               end else if (cnt_q >= CNT_LIMIT) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            MEAS: begin
               if (rise) begin
                  period_d  = cnt_q;
                  high_d    = hi_cap_q;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = CNT_ONE;
                  hi_cap_d  = '0;
               end else if (cnt_q >= CNT_LIMIT) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ARM;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (fall) begin
                     hi_cap_d = cnt_q;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a scoreboard queue of expected measurements is
// filled as each rising edge is driven and drained whenever valid pulses.
module tb_period_meter;

   localparam int CW      = 32;
   localparam int TIMEOUT = 50;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          sig_in;
   logic          enable;
   logic [CW-1:0] period_out;
   logic [CW-1:0] high_out;
   logic          valid;
   logic          timeout;
   logic          measuring;

   typedef struct {
      int per;
      int hi;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_valid_cyc = 0;
   int valid_count = 0;
   bit tracking = 1'b1;
   bit have_prev = 1'b0;
   int prev_per = 0;
   int prev_hi = 0;
   bit found;

   period_meter #(
      .CNT_WIDTH(CW),
      .TIMEOUT_CYCLES(TIMEOUT),
      .SYNC_STAGES(2)
   ) dut (
      .clk_in(clk_in),
      .reset(reset),
      .sig_in(sig_in),
      .enable(enable),
      .period_out(period_out),
      .high_out(high_out),
      .valid(valid),
      .timeout(timeout),
      .measuring(measuring)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expd);
      end
   endtask

   // Drives one period starting at posedge+1; the previous period's result is
   // queued just before the rise that closes it.
   task automatic pulse(input int hi, input int lo);
      if (tracking && have_prev) begin
         exp_q.push_back('{per: prev_per, hi: prev_hi});
      end
      sig_in = 1'b1;
      repeat (hi) @(posedge clk_in);
      #1 sig_in = 1'b0;
      repeat (lo) @(posedge clk_in);
      #1;
      prev_per  = hi + lo;
      prev_hi   = hi;
      have_prev = tracking;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Every valid pulse must match the oldest queued expectation and clear timeout.
   always @(negedge clk_in) begin
      if (reset === 1'b1 && valid === 1'b1) begin
         valid_count++;
         last_valid_cyc = cyc;
         check_output("valid_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_output("period_out", period_out, mon_e.per);
            check_output("high_out", high_out, mon_e.hi);
            check_output("timeout_on_valid", {31'b0, timeout}, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_output("rst_period", period_out, 0);
      check_output("rst_high", high_out, 0);
      check_output("rst_valid", {31'b0, valid}, 0);
      check_output("rst_timeout", {31'b0, timeout}, 0);
      check_output("rst_measuring", {31'b0, measuring}, 0);
      reset = 1'b1;

      // Square wave, 4 high / 4 low
      @(posedge clk_in);
      #1 enable = 1'b1;
      idle_cycles(3);
      check_output("arm_measuring", {31'b0, measuring}, 0);
      repeat (5) pulse(4, 4);
      check_output("sq_measuring", {31'b0, measuring}, 1);
      check_output("sq_pending", exp_q.size(), 0);
      check_output("sq_valid_count", valid_count, 4);

      // Duty cycle 3 high / 7 low
      repeat (4) pulse(3, 7);
      check_output("duty_pending", exp_q.size(), 0);

      // Period equal to the timeout limit: the rise must win
      repeat (3) pulse(20, 30);
      check_output("limit_timeout", {31'b0, timeout}, 0);

      // Signal held low: timeout exactly TIMEOUT cycles after the last valid
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk_in);
         if (timeout === 1'b1) found = 1'b1;
      end
      check_output("timeout_seen", {31'b0, found}, 1);
      check_output("timeout_delay", cyc - last_valid_cyc, TIMEOUT);
      check_output("to_period_held", period_out, 50);
      check_output("to_high_held", high_out, 20);
      check_output("to_measuring", {31'b0, measuring}, 0);
      have_prev = 1'b0;

      // Restart: first rise only re-arms, next rise clears timeout
      @(posedge clk_in);
      #1;
      pulse(4, 4);
      check_output("restart_timeout_sticky", {31'b0, timeout}, 1);
      repeat (2) pulse(4, 4);
      check_output("restart_timeout_clear", {31'b0, timeout}, 0);
      check_output("restart_pending", exp_q.size(), 0);

      // Enable dropped mid-period discards the pending measurement
      idle_cycles(2);
      enable    = 1'b0;
      tracking  = 1'b0;
      have_prev = 1'b0;
      idle_cycles(3);
      repeat (2) pulse(4, 4);
      check_output("dis_measuring", {31'b0, measuring}, 0);
      check_output("dis_period_held", period_out, 8);
      check_output("dis_high_held", high_out, 4);
      check_output("dis_timeout_held", {31'b0, timeout}, 0);
      tracking = 1'b1;
      enable   = 1'b1;
      idle_cycles(3);
      pulse(4, 4);
      check_output("reen_measuring", {31'b0, measuring}, 1);
      repeat (2) pulse(4, 4);
      check_output("reen_pending", exp_q.size(), 0);

      // Asynchronous reset between clock edges mid-measurement
      @(posedge clk_in);
      #3 reset = 1'b0;
      #1;
      check_output("arst_period", period_out, 0);
      check_output("arst_high", high_out, 0);
      check_output("arst_valid", {31'b0, valid}, 0);
      check_output("arst_timeout", {31'b0, timeout}, 0);
      check_output("arst_measuring", {31'b0, measuring}, 0);
      have_prev = 1'b0;
      repeat (2) @(negedge clk_in);
      reset = 1'b1;
      @(posedge clk_in);
      #1;
      repeat (3) pulse(3, 7);
      idle_cycles(5);
      check_output("final_pending", exp_q.size(), 0);
      check_output("final_valid_count", valid_count, 4 + 4 + 3 + 2 + 2 + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
